// File: rtl/lc3_pkg.sv
// Shared LC-3 register-file definitions: select-code encodings, CC reset value, default width.
// Pure constants; no logic, no latency.
package lc3_pkg;

    localparam int LC3_DATA_W = 16;

    // SR1 address select codes
    localparam logic [1:0] SR1_IR11_9 = 2'b00;
    localparam logic [1:0] SR1_IR8_6  = 2'b01;
    localparam logic [1:0] SR1_SP     = 2'b10;

    // DR address select codes
    localparam logic [1:0] DR_IR11_9  = 2'b00;
    localparam logic [1:0] DR_LINK    = 2'b01;
    localparam logic [1:0] DR_SP      = 2'b10;

    // Shared by both selects; resolves to register 0 and raises the error flag
    localparam logic [1:0] SEL_RESERVED = 2'b11;

    localparam logic [2:0] CC_Z = 3'b010;

endpackage

// File: rtl/lc3_reg_addr_mux.sv
// 4-way register-index select with a reserved-code flag; code 11 resolves to index 0.
// Purely combinational (zero latency); no flow control.
module lc3_reg_addr_mux
    import lc3_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] idx0,
    input  logic [ADDR_W-1:0] idx1,
    input  logic [ADDR_W-1:0] idx2,
    output logic [ADDR_W-1:0] idx,
    output logic              reserved
);

    always_comb begin
        idx      = '0;
        reserved = 1'b0;
        case (sel)
            2'b00:        idx = idx0;
            2'b01:        idx = idx1;
            2'b10:        idx = idx2;
            SEL_RESERVED: reserved = 1'b1;
            default:      idx = '0;
        endcase
    end

endmodule

// File: rtl/lc3_regfile_sel.sv
// LC-3 register file with IR/fixed-register address select, write-to-read forwarding and NZP codes.
// Reads and CC updates land one cycle after rd_en/ld_cc; no backpressure, control FSM sequences it.
module lc3_regfile_sel
    import lc3_pkg::*;
#(
    parameter int DATA_W   = LC3_DATA_W,
    parameter int NREG     = 8,
    parameter int ADDR_W   = $clog2(NREG),
    parameter int SP_REG   = 6,
    parameter int LINK_REG = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ir_11_9,
    input  logic [ADDR_W-1:0] ir_8_6,
    input  logic [ADDR_W-1:0] ir_2_0,
    input  logic [1:0]        sr1_sel,
    input  logic [1:0]        dr_sel,
    input  logic              rd_en,
    input  logic              ld_reg,
    input  logic              ld_cc,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] sr1_out,
    output logic [DATA_W-1:0] sr2_out,
    output logic [2:0]        nzp,
    output logic              sel_err
);

    localparam logic [ADDR_W-1:0] SP_IDX   = ADDR_W'(SP_REG);
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic [ADDR_W-1:0] sr1_idx;
    logic [ADDR_W-1:0] dr_idx;
    logic              sr1_rsv;
    logic              dr_rsv;
    logic [DATA_W-1:0] sr1_rd;
    logic [DATA_W-1:0] sr2_rd;
    logic [2:0]        cc_next;

    lc3_reg_addr_mux #(.ADDR_W(ADDR_W)) u_sr1_mux (
        .sel      (sr1_sel),
        .idx0     (ir_11_9),
        .idx1     (ir_8_6),
        .idx2     (SP_IDX),
        .idx      (sr1_idx),
        .reserved (sr1_rsv)
    );

    lc3_reg_addr_mux #(.ADDR_W(ADDR_W)) u_dr_mux (
        .sel      (dr_sel),
        .idx0     (ir_11_9),
        .idx1     (LINK_IDX),
        .idx2     (SP_IDX),
        .idx      (dr_idx),
        .reserved (dr_rsv)
    );

    // A same-cycle write to an operand's register wins over the stored value.
    always_comb begin
        sr1_rd = regs[sr1_idx];
        sr2_rd = regs[ir_2_0];
        if (ld_reg && (sr1_idx == dr_idx)) sr1_rd = bus_in;
        if (ld_reg && (ir_2_0 == dr_idx))  sr2_rd = bus_in;
    end

    always_comb begin
        cc_next    = 3'b000;
        cc_next[2] = bus_in[DATA_W-1];
        cc_next[1] = (bus_in == '0);
        cc_next[0] = !bus_in[DATA_W-1] && (bus_in != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            sr1_out <= '0;
            sr2_out <= '0;
            nzp     <= CC_Z;
            sel_err <= 1'b0;
        end else begin
            if (ld_reg) regs[dr_idx] <= bus_in;
            if (rd_en) begin
                sr1_out <= sr1_rd;
                sr2_out <= sr2_rd;
            end
            if (ld_cc) nzp <= cc_next;
            sel_err <= (rd_en && sr1_rsv) || (ld_reg && dr_rsv);
        end
    end

endmodule
